// File: rtl/ap_ctrl_chain_driver.sv
// ap_ctrl_chain initiator: launches commanded transactions into a kernel
// and emits one latency record per completion. Option: AP_CTRL_DRV_TIMEOUT_EN.
module ap_ctrl_chain_driver #(
  parameter int TXN_W   = 16,
  parameter int CNT_W   = 32,
  parameter int MAX_OUT = 4
`ifdef AP_CTRL_DRV_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 100000
`endif
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [TXN_W-1:0] cmd_count,
  output logic             dut_ap_start,
  input  logic             dut_ap_ready,
  input  logic             dut_ap_done,
  output logic             dut_ap_continue,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [TXN_W-1:0] rec_index,
  output logic [CNT_W-1:0] rec_latency,
  output logic             busy,
  output logic             done_pulse,
  output logic             proto_err
`ifdef AP_CTRL_DRV_TIMEOUT_EN
  ,
  output logic             timeout
`endif
);

  localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int OUT_W = $clog2(MAX_OUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FINISH
  } state_e;

  state_e            state_q, state_d;
  logic [TXN_W-1:0]  count_q, count_d;
  logic [TXN_W-1:0]  launched_q, launched_d;
  logic [TXN_W-1:0]  completed_q, completed_d;
  logic [OUT_W-1:0]  outst_q, outst_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  fifo_q [MAX_OUT];
  logic [CNT_W-1:0]  fifo_d [MAX_OUT];
  logic              rec_valid_q, rec_valid_d;
  logic [TXN_W-1:0]  rec_index_q, rec_index_d;
  logic [CNT_W-1:0]  rec_latency_q, rec_latency_d;
  logic              proto_err_q, proto_err_d;
`ifdef AP_CTRL_DRV_TIMEOUT_EN
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  wd_q, wd_d;
`endif

  logic acc;
  logic dn;
  logic cmd_acc;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + 1'b1;
  endfunction

  assign cmd_ready       = (state_q == S_IDLE);
  assign busy            = (state_q != S_IDLE);
  assign done_pulse      = (state_q == S_FINISH);
  assign dut_ap_start    = (state_q == S_RUN) &&
                           (launched_q < count_q) &&
                           (outst_q < OUT_W'(MAX_OUT));
  assign dut_ap_continue = busy && (!rec_valid_q || rec_ready);
  assign acc             = dut_ap_start && dut_ap_ready;
  assign dn              = dut_ap_done && dut_ap_continue && (outst_q != '0);
  assign cmd_acc         = cmd_valid && cmd_ready;
  assign rec_valid       = rec_valid_q;
  assign rec_index       = rec_index_q;
  assign rec_latency     = rec_latency_q;
  assign proto_err       = proto_err_q;
`ifdef AP_CTRL_DRV_TIMEOUT_EN
  assign timeout         = timeout_q;
`endif

  // Next-state: timestamp FIFO, counters, record register and FSM.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    launched_d    = launched_q;
    completed_d   = completed_q;
    outst_d       = outst_q;
    cyc_d         = cyc_q + 1'b1;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    fifo_d        = fifo_q;
    rec_valid_d   = rec_valid_q;
    rec_index_d   = rec_index_q;
    rec_latency_d = rec_latency_q;
    proto_err_d   = proto_err_q;
`ifdef AP_CTRL_DRV_TIMEOUT_EN
    timeout_d     = timeout_q;
    wd_d          = wd_q;
`endif

    if (dut_ap_done && (outst_q == '0)) proto_err_d = 1'b1;

    if (acc) begin
      fifo_d[wr_ptr_q] = cyc_q;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
      launched_d       = launched_q + 1'b1;
    end

    if (dn) begin
      rd_ptr_d      = ptr_inc(rd_ptr_q);
      rec_latency_d = cyc_q - fifo_q[rd_ptr_q];
      rec_index_d   = completed_q;
      rec_valid_d   = 1'b1;
      completed_d   = completed_q + 1'b1;
    end else if (rec_ready) begin
      rec_valid_d = 1'b0;
    end

    if (acc && !dn) outst_d = outst_q + 1'b1;
    else if (!acc && dn) outst_d = outst_q - 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_acc) begin
          count_d     = cmd_count;
          launched_d  = '0;
          completed_d = '0;
          outst_d     = '0;
          wr_ptr_d    = '0;
          rd_ptr_d    = '0;
`ifdef AP_CTRL_DRV_TIMEOUT_EN
          timeout_d   = 1'b0;
          wd_d        = '0;
`endif
          state_d     = (cmd_count == '0) ? S_FINISH : S_RUN;
        end
      end
      S_RUN: begin
        if ((completed_q == count_q) && !rec_valid_q) state_d = S_FINISH;
`ifdef AP_CTRL_DRV_TIMEOUT_EN
        if (acc || dn) begin
          wd_d = '0;
        end else begin
          wd_d = wd_q + 1'b1;
          if (wd_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            timeout_d = 1'b1;
            state_d   = S_FINISH;
          end
        end
`endif
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q       <= S_IDLE;
      count_q       <= '0;
      launched_q    <= '0;
      completed_q   <= '0;
      outst_q       <= '0;
      cyc_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fifo_q        <= '{default: '0};
      rec_valid_q   <= 1'b0;
      rec_index_q   <= '0;
      rec_latency_q <= '0;
      proto_err_q   <= 1'b0;
`ifdef AP_CTRL_DRV_TIMEOUT_EN
      timeout_q     <= 1'b0;
      wd_q          <= '0;
`endif
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      launched_q    <= launched_d;
      completed_q   <= completed_d;
      outst_q       <= outst_d;
      cyc_q         <= cyc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fifo_q        <= fifo_d;
      rec_valid_q   <= rec_valid_d;
      rec_index_q   <= rec_index_d;
      rec_latency_q <= rec_latency_d;
      proto_err_q   <= proto_err_d;
`ifdef AP_CTRL_DRV_TIMEOUT_EN
      timeout_q     <= timeout_d;
      wd_q          <= wd_d;
`endif
    end
  end

endmodule

// File: tb/tb_ap_ctrl_chain_driver.sv
// Bench for ap_ctrl_chain_driver: kernel model plus record scoreboard,
// one task per scenario.
module tb_ap_ctrl_chain_driver;

  localparam int TXN_W = 16;
  localparam int CNT_W = 32;

  logic             clk;
  logic             ap_rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [TXN_W-1:0] cmd_count;
  logic             dut_ap_start;
  logic             dut_ap_ready;
  logic             dut_ap_done;
  logic             dut_ap_continue;
  logic             rec_valid;
  logic             rec_ready;
  logic [TXN_W-1:0] rec_index;
  logic [CNT_W-1:0] rec_latency;
  logic             busy;
  logic             done_pulse;
  logic             proto_err;
`ifdef AP_CTRL_DRV_TIMEOUT_EN
  logic             timeout;
`endif

  ap_ctrl_chain_driver #(
    .TXN_W(TXN_W),
    .CNT_W(CNT_W),
    .MAX_OUT(4)
`ifdef AP_CTRL_DRV_TIMEOUT_EN
    ,
    .TIMEOUT_CYC(50)
`endif
  ) dut (
    .ap_clk(clk),
    .ap_rst(ap_rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_count(cmd_count),
    .dut_ap_start(dut_ap_start),
    .dut_ap_ready(dut_ap_ready),
    .dut_ap_done(dut_ap_done),
    .dut_ap_continue(dut_ap_continue),
    .rec_valid(rec_valid),
    .rec_ready(rec_ready),
    .rec_index(rec_index),
    .rec_latency(rec_latency),
    .busy(busy),
    .done_pulse(done_pulse),
    .proto_err(proto_err)
`ifdef AP_CTRL_DRV_TIMEOUT_EN
    ,
    .timeout(timeout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit k_ready = 1'b1;
  bit k_manual = 1'b0;
  bit k_release = 1'b0;
  bit k_force = 1'b0;
  int k_lat = 10;

  int due[$];
  int acc_t[$];
  int exp_idx[$];
  int exp_lat[$];
  int got_idx[$];
  int got_lat[$];
  int comp_n = 0;
  int nacc = 0;
  int nrec = 0;
  int npulse = 0;
  int m_ei, m_el, m_t0;

  always @(posedge clk) cyc <= cyc + 1;

  // Kernel model and record scoreboard; handshakes resolved before each edge.
  always begin
    @(negedge clk);
    #1;
    dut_ap_ready = k_ready;
    dut_ap_done  = k_force ||
                   (due.size() > 0 &&
                    (k_manual ? k_release : (cyc + 1 >= due[0])));
    #1;
    if (ap_rst) begin
      due.delete();
      acc_t.delete();
      exp_idx.delete();
      exp_lat.delete();
      comp_n = 0;
    end else begin
      if (cmd_valid && cmd_ready) comp_n = 0;
      if (done_pulse) npulse++;
      if (rec_valid && rec_ready) begin
        nrec++;
        got_idx.push_back(int'(rec_index));
        got_lat.push_back(int'(rec_latency));
        checks++;
        if (exp_idx.size() == 0) begin
          errors++;
          $display("FAIL rec_unexpected idx=%0d lat=%0d", rec_index, rec_latency);
        end else begin
          m_ei = exp_idx.pop_front();
          m_el = exp_lat.pop_front();
          if (int'(rec_index) !== m_ei || int'(rec_latency) !== m_el) begin
            errors++;
            $display("FAIL rec_scoreboard got idx=%0d lat=%0d exp idx=%0d lat=%0d",
                     rec_index, rec_latency, m_ei, m_el);
          end
        end
      end
      if (dut_ap_start && dut_ap_ready) begin
        acc_t.push_back(cyc + 1);
        due.push_back(cyc + 1 + k_lat);
        nacc++;
      end
      if (dut_ap_done && dut_ap_continue && due.size() > 0) begin
        m_t0 = acc_t.pop_front();
        void'(due.pop_front());
        exp_idx.push_back(comp_n);
        exp_lat.push_back(cyc + 1 - m_t0);
        comp_n++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1);
  end

  task automatic issue(input int n);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_count = TXN_W'(n);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_pulse(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #3;
      if (npulse >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    ap_rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_count = '0;
    rec_ready = 1'b1;
    repeat (3) @(negedge clk);
    #3;
    checks++;
    if ({dut_ap_start, dut_ap_continue, rec_valid, busy, done_pulse, proto_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 000000",
               {dut_ap_start, dut_ap_continue, rec_valid, busy, done_pulse, proto_err});
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready);
    end
    checks++;
    if (rec_index !== '0 || rec_latency !== '0) begin
      errors++;
      $display("FAIL reset_rec got idx=%0d lat=%0d exp 0 0", rec_index, rec_latency);
    end
    @(negedge clk);
    ap_rst = 1'b0;
  endtask

  task automatic test_basic;
    int n0, r0, l0;
    bit ok, bad;
    k_ready = 1'b1;
    k_manual = 1'b0;
    k_lat = 10;
    n0 = npulse;
    r0 = nrec;
    l0 = got_lat.size();
    issue(3);
    #3;
    checks++;
    if (dut_ap_start !== 1'b1 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_start got start=%b cmd_ready=%b exp 1 0", dut_ap_start, cmd_ready);
    end
    wait_pulse(n0 + 1, 200, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_pulse_wait got none exp done_pulse");
    end
    @(negedge clk);
    #3;
    checks++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_idle got busy=%b cmd_ready=%b exp 0 1", busy, cmd_ready);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (npulse - n0 !== 1 || nrec - r0 !== 3) begin
      errors++;
      $display("FAIL basic_counts got pulses=%0d recs=%0d exp 1 3", npulse - n0, nrec - r0);
    end
    bad = 1'b0;
    for (int i = 0; i < 3; i++)
      if (got_lat.size() <= l0 + i || got_lat[l0 + i] != 10 || got_idx[l0 + i] != i)
        bad = 1'b1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL basic_latency got mismatch in 3 records exp idx 0..2 lat 10");
    end
  endtask

  task automatic test_max_out;
    int a0, n0, r0, l0;
    bit ok, bad;
    k_ready = 1'b1;
    k_manual = 1'b1;
    k_release = 1'b0;
    a0 = nacc;
    n0 = npulse;
    r0 = nrec;
    l0 = got_idx.size();
    issue(8);
    repeat (10) @(negedge clk);
    #3;
    checks++;
    if (nacc - a0 !== 4 || dut_ap_start !== 1'b0) begin
      errors++;
      $display("FAIL maxout_cap got acc=%0d start=%b exp 4 0", nacc - a0, dut_ap_start);
    end
    @(negedge clk);
    k_release = 1'b1;
    wait_pulse(n0 + 1, 100, ok);
    k_release = 1'b0;
    k_manual = 1'b0;
    checks++;
    if (!ok || nrec - r0 !== 8 || nacc - a0 !== 8) begin
      errors++;
      $display("FAIL maxout_drain got ok=%b recs=%0d acc=%0d exp 1 8 8",
               ok, nrec - r0, nacc - a0);
    end
    bad = 1'b0;
    for (int i = 0; i < 8; i++)
      if (got_idx.size() <= l0 + i || got_idx[l0 + i] != i) bad = 1'b1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL maxout_order got out-of-order indices exp 0..7");
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_stall;
    int n0, r0, l0;
    bit ok, seen, bad;
    k_ready = 1'b1;
    k_manual = 1'b0;
    k_lat = 5;
    n0 = npulse;
    r0 = nrec;
    l0 = got_lat.size();
    @(negedge clk);
    rec_ready = 1'b0;
    issue(3);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #3;
      if (rec_valid) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL stall_first_rec got none exp rec_valid");
    end
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #3;
      if (dut_ap_continue !== 1'b0 || rec_valid !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad || nrec !== r0 || rec_index !== '0) begin
      errors++;
      $display("FAIL stall_hold got bad=%b recs=%0d idx=%0d exp 0 0 0",
               bad, nrec - r0, rec_index);
    end
    @(negedge clk);
    rec_ready = 1'b1;
    wait_pulse(n0 + 1, 100, ok);
    checks++;
    if (!ok || nrec - r0 !== 3) begin
      errors++;
      $display("FAIL stall_drain got ok=%b recs=%0d exp 1 3", ok, nrec - r0);
    end
    checks++;
    if (got_lat.size() < l0 + 3 || got_lat[l0] != 5 || got_lat[l0 + 1] <= 20) begin
      errors++;
      $display("FAIL stall_latency got first/second lat mismatch exp 5 and >20");
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_zero;
    int a0;
    a0 = nacc;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_count = '0;
    @(negedge clk);
    cmd_valid = 1'b0;
    #3;
    checks++;
    if (done_pulse !== 1'b1 || dut_ap_start !== 1'b0) begin
      errors++;
      $display("FAIL zero_pulse got pulse=%b start=%b exp 1 0", done_pulse, dut_ap_start);
    end
    @(negedge clk);
    #3;
    checks++;
    if (done_pulse !== 1'b0 || cmd_ready !== 1'b1 || nacc !== a0) begin
      errors++;
      $display("FAIL zero_idle got pulse=%b cmd_ready=%b acc=%0d exp 0 1 0",
               done_pulse, cmd_ready, nacc - a0);
    end
  endtask

  task automatic test_proto;
    #3;
    checks++;
    if (proto_err !== 1'b0) begin
      errors++;
      $display("FAIL proto_pre got %b exp 0", proto_err);
    end
    @(negedge clk);
    k_force = 1'b1;
    @(negedge clk);
    k_force = 1'b0;
    #3;
    checks++;
    if (proto_err !== 1'b1 || rec_valid !== 1'b0) begin
      errors++;
      $display("FAIL proto_set got err=%b rec_valid=%b exp 1 0", proto_err, rec_valid);
    end
    repeat (2) @(negedge clk);
    #3;
    checks++;
    if (proto_err !== 1'b1 || rec_valid !== 1'b0) begin
      errors++;
      $display("FAIL proto_sticky got err=%b rec_valid=%b exp 1 0", proto_err, rec_valid);
    end
  endtask

  task automatic test_reset_mid;
    k_ready = 1'b1;
    k_manual = 1'b0;
    k_lat = 2;
    @(negedge clk);
    rec_ready = 1'b0;
    issue(8);
    repeat (8) @(negedge clk);
    #3;
    checks++;
    if (busy !== 1'b1 || rec_valid !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre got busy=%b rec_valid=%b exp 1 1", busy, rec_valid);
    end
    @(negedge clk);
    ap_rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({dut_ap_start, dut_ap_continue, rec_valid, busy, done_pulse, proto_err} !== 6'b0 ||
        cmd_ready !== 1'b1 || rec_index !== '0 || rec_latency !== '0) begin
      errors++;
      $display("FAIL midrst_clear got ctl=%b cmd_ready=%b idx=%0d lat=%0d exp 000000 1 0 0",
               {dut_ap_start, dut_ap_continue, rec_valid, busy, done_pulse, proto_err},
               cmd_ready, rec_index, rec_latency);
    end
    @(negedge clk);
    ap_rst = 1'b0;
    rec_ready = 1'b1;
    repeat (2) @(negedge clk);
  endtask

`ifdef AP_CTRL_DRV_TIMEOUT_EN
  task automatic test_timeout;
    int s, d;
    bit seen;
    k_ready = 1'b0;
    issue(2);
    #3;
    s = cyc;
    checks++;
    if (dut_ap_start !== 1'b1) begin
      errors++;
      $display("FAIL tmo_start got %b exp 1", dut_ap_start);
    end
    seen = 1'b0;
    d = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #3;
      if (done_pulse) begin
        seen = 1'b1;
        d = cyc - s;
        break;
      end
    end
    checks++;
    if (!seen || d < 50 || d > 51 || timeout !== 1'b1) begin
      errors++;
      $display("FAIL tmo_fire got seen=%b dist=%0d timeout=%b exp 1 50..51 1",
               seen, d, timeout);
    end
    k_ready = 1'b1;
    repeat (2) @(negedge clk);
  endtask
`endif

  initial begin
    dut_ap_ready = 1'b0;
    dut_ap_done = 1'b0;
    test_reset();
    test_basic();
    test_max_out();
    test_stall();
    test_zero();
    test_proto();
    test_reset_mid();
`ifdef AP_CTRL_DRV_TIMEOUT_EN
    test_timeout();
`endif
    checks++;
    if (exp_idx.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d exp 0", exp_idx.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
